// File: rtl/invader_fire_ctrl_if.sv
// Bundle between the invader grid, the invader shot slots and the fire scheduler.
// The master side is the scheduler: it reads grid/slot state and issues launches.
interface invader_fire_ctrl_if #(
    parameter int unsigned N_SLOTS = 3
);
    logic               Enable;
    logic [9:0]         InvaderX [50];
    logic [9:0]         InvaderY [50];
    logic [49:0]        InvaderOn;
    logic [N_SLOTS-1:0] SlotBusy;
    logic [N_SLOTS-1:0] Launch;
    logic [9:0]         LaunchX;
    logic [9:0]         LaunchY;
    logic [9:0]         LaunchS;
    logic [15:0]        FireCount;

    modport master (
        input  Enable, InvaderX, InvaderY, InvaderOn, SlotBusy,
        output Launch, LaunchX, LaunchY, LaunchS, FireCount
    );

    modport slave (
        output Enable, InvaderX, InvaderY, InvaderOn, SlotBusy,
        input  Launch, LaunchX, LaunchY, LaunchS, FireCount
    );
endinterface

// File: rtl/invader_fire_ctrl.sv
// Invader return-fire scheduler: jittered cooldown, random column pick, bottom-up
// column scan for the lowest live invader, and a one-cycle launch to a free shot slot.
module invader_fire_ctrl #(
    parameter int unsigned N_SLOTS     = 3,
    parameter logic [9:0]  COOLDOWN    = 10'd60,
    parameter logic [5:0]  JITTER_MASK = 6'h1F,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                frame_clk,
    input  logic                Reset,
    invader_fire_ctrl_if.master bus
);

    localparam int unsigned SLOT_W   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [1:0] {StIdle, StPick, StScan, StFire} state_e;

    state_e              state;
    logic [9:0]          cnt;
    logic [15:0]         lfsr;
    logic [3:0]          col;
    logic [2:0]          row;
    logic [3:0]          tries;
    logic [SLOT_W-1:0]   slot;
    logic [9:0]          launch_x;
    logic [9:0]          launch_y;
    logic [9:0]          launch_s;
    logic [15:0]         fire_count;

    logic [5:0]          idx;
    logic [15:0]         lfsr_next;
    logic [9:0]          reload;
    logic [3:0]          pick_col;
    logic [SLOT_W-1:0]   free_slot;
    logic [9:0]          row_size;
    logic                all_busy;
    logic                fire_ok;

    assign idx       = ({3'b000, row} * 6'd10) + {2'b00, col};
    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign reload    = COOLDOWN + {4'b0000, lfsr[9:4] & JITTER_MASK};
    assign pick_col  = (lfsr[3:0] >= 4'd10) ? (lfsr[3:0] - 4'd10) : lfsr[3:0];
    assign all_busy  = &bus.SlotBusy;

    always_comb begin
        free_slot = '0;
        for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
            if (!bus.SlotBusy[i]) free_slot = SLOT_W'(i);
        end
    end

    // Bottom rows hold the larger invader sprites.
    always_comb begin
        unique case (row)
            3'd0:       row_size = 10'd8;
            3'd1, 3'd2: row_size = 10'd9;
            default:    row_size = 10'd10;
        endcase
    end

    // Abort the launch if the slot got taken or the shooter died after the latch.
    assign fire_ok = (state == StFire) && bus.Enable && !bus.SlotBusy[slot] && bus.InvaderOn[idx];

    always_comb begin
        bus.Launch = '0;
        if (fire_ok) bus.Launch[slot] = 1'b1;
    end

    assign bus.LaunchX   = launch_x;
    assign bus.LaunchY   = launch_y;
    assign bus.LaunchS   = launch_s;
    assign bus.FireCount = fire_count;

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state      <= StIdle;
            cnt        <= COOLDOWN;
            lfsr       <= SEED_EFF;
            col        <= 4'd0;
            row        <= 3'd4;
            tries      <= 4'd0;
            slot       <= '0;
            launch_x   <= 10'd0;
            launch_y   <= 10'd0;
            launch_s   <= 10'd0;
            fire_count <= 16'd0;
        end else if (!bus.Enable) begin
            state <= StIdle;
            cnt   <= reload;
        end else begin
            unique case (state)
                StIdle: begin
                    if (cnt != 10'd0) cnt   <= cnt - 10'd1;
                    else              state <= StPick;
                end
                StPick: begin
                    if (!all_busy) begin
                        slot  <= free_slot;
                        col   <= pick_col;
                        row   <= 3'd4;
                        tries <= 4'd0;
                        lfsr  <= lfsr_next;
                        state <= StScan;
                    end
                end
                StScan: begin
                    if (bus.InvaderOn[idx]) begin
                        launch_x <= bus.InvaderX[idx];
                        launch_y <= bus.InvaderY[idx];
                        launch_s <= row_size;
                        state    <= StFire;
                    end else if (row != 3'd0) begin
                        row <= row - 3'd1;
                    end else begin
                        col   <= (col == 4'd9) ? 4'd0 : col + 4'd1;
                        tries <= tries + 4'd1;
                        row   <= 3'd4;
                        // Tenth empty column means the grid is clear.
                        if (tries == 4'd9) begin
                            state <= StIdle;
                            cnt   <= reload;
                        end
                    end
                end
                StFire: begin
                    if (fire_ok) begin
                        fire_count <= fire_count + 16'd1;
                        state      <= StIdle;
                        cnt        <= reload;
                    end else begin
                        row   <= 3'd4;
                        state <= StScan;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_invader_fire_ctrl.sv
// Directed bench for invader_fire_ctrl with COOLDOWN=4, no jitter, SEED=ACE1.
// Hand-derived LFSR columns per pick after reset: 1, 3, 7, ...
module tb_invader_fire_ctrl;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    invader_fire_ctrl_if #(.N_SLOTS(3)) ifc ();

    invader_fire_ctrl #(
        .N_SLOTS    (3),
        .COOLDOWN   (10'd4),
        .JITTER_MASK(6'h00),
        .SEED       (16'hACE1)
    ) dut (
        .frame_clk(clk),
        .Reset    (rst_n),
        .bus      (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advances until a Launch bit is seen; n = edges taken, or -1 if the budget ran out.
    task automatic run_to_launch(input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            if (|ifc.Launch) begin
                n = k;
                return;
            end
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        ifc.Enable     = 1'b0;
        ifc.SlotBusy   = 3'b000;
        ifc.InvaderOn  = '1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.Enable = 1'b1;
        #3;
        tests++; if (ifc.Launch !== 3'b000) begin fails++; $display("FAIL reset_launch got %b want 000", ifc.Launch); end
        tests++; if (ifc.LaunchX !== 10'd0) begin fails++; $display("FAIL reset_x got %0d want 0", ifc.LaunchX); end
        tests++; if (ifc.LaunchY !== 10'd0) begin fails++; $display("FAIL reset_y got %0d want 0", ifc.LaunchY); end
        tests++; if (ifc.LaunchS !== 10'd0) begin fails++; $display("FAIL reset_s got %0d want 0", ifc.LaunchS); end
        tests++; if (ifc.FireCount !== 16'd0) begin fails++; $display("FAIL reset_count got %0d want 0", ifc.FireCount); end
        do_reset();
    endtask

    task automatic test_first_launch();
        int n;
        do_reset();
        ifc.Enable = 1'b1;
        run_to_launch(30, n);
        tests++; if (n !== 7) begin fails++; $display("FAIL first_latency got %0d want 7", n); end
        tests++; if (ifc.Launch !== 3'b001) begin fails++; $display("FAIL first_launch got %b want 001", ifc.Launch); end
        tests++; if (ifc.LaunchX !== 10'd141) begin fails++; $display("FAIL first_x got %0d want 141", ifc.LaunchX); end
        tests++; if (ifc.LaunchY !== 10'd241) begin fails++; $display("FAIL first_y got %0d want 241", ifc.LaunchY); end
        tests++; if (ifc.LaunchS !== 10'd10) begin fails++; $display("FAIL first_s got %0d want 10", ifc.LaunchS); end
        @(posedge clk); #1;
        tests++; if (ifc.Launch !== 3'b000) begin fails++; $display("FAIL first_pulse_len got %b want 000", ifc.Launch); end
        tests++; if (ifc.FireCount !== 16'd1) begin fails++; $display("FAIL first_count got %0d want 1", ifc.FireCount); end
        // Second pick (col 3) with only invaders 3 and 13 alive: four SCAN cycles.
        ifc.InvaderOn = '0;
        ifc.InvaderOn[3]  = 1'b1;
        ifc.InvaderOn[13] = 1'b1;
        run_to_launch(30, n);
        tests++; if (n !== 10) begin fails++; $display("FAIL scan_latency got %0d want 10", n); end
        tests++; if (ifc.LaunchX !== 10'd113) begin fails++; $display("FAIL scan_x got %0d want 113", ifc.LaunchX); end
        tests++; if (ifc.LaunchY !== 10'd213) begin fails++; $display("FAIL scan_y got %0d want 213", ifc.LaunchY); end
        tests++; if (ifc.LaunchS !== 10'd9) begin fails++; $display("FAIL scan_s got %0d want 9", ifc.LaunchS); end
        @(posedge clk); #1;
        tests++; if (ifc.FireCount !== 16'd2) begin fails++; $display("FAIL scan_count got %0d want 2", ifc.FireCount); end
    endtask

    task automatic test_empty_grid();
        int n;
        do_reset();
        ifc.InvaderOn = '0;
        ifc.Enable = 1'b1;
        // 4 countdown + PICK + enter SCAN + 50 SCAN cycles = 56 edges, back in IDLE.
        run_to_launch(56, n);
        tests++; if (n !== -1) begin fails++; $display("FAIL empty_no_launch got edge %0d want none", n); end
        tests++; if (ifc.FireCount !== 16'd0) begin fails++; $display("FAIL empty_count got %0d want 0", ifc.FireCount); end
        ifc.InvaderOn = '1;
        run_to_launch(30, n);
        tests++; if (n !== 7) begin fails++; $display("FAIL empty_reload got %0d want 7", n); end
        tests++; if (ifc.LaunchX !== 10'd143) begin fails++; $display("FAIL empty_next_x got %0d want 143", ifc.LaunchX); end
    endtask

    task automatic test_all_busy();
        int n;
        do_reset();
        ifc.SlotBusy = 3'b111;
        ifc.Enable = 1'b1;
        run_to_launch(25, n);
        tests++; if (n !== -1) begin fails++; $display("FAIL busy_no_launch got edge %0d want none", n); end
        ifc.SlotBusy = 3'b101;
        run_to_launch(10, n);
        tests++; if (n !== 2) begin fails++; $display("FAIL busy_latency got %0d want 2", n); end
        tests++; if (ifc.Launch !== 3'b010) begin fails++; $display("FAIL busy_slot got %b want 010", ifc.Launch); end
        // Column 1 proves the LFSR held while waiting in PICK.
        tests++; if (ifc.LaunchX !== 10'd141) begin fails++; $display("FAIL busy_x got %0d want 141", ifc.LaunchX); end
    endtask

    task automatic test_kill_in_fire();
        int n;
        do_reset();
        ifc.Enable = 1'b1;
        run_to_launch(30, n);
        tests++; if (n !== 7) begin fails++; $display("FAIL kill_pre_latency got %0d want 7", n); end
        ifc.InvaderOn[41] = 1'b0;
        #1;
        tests++; if (ifc.Launch !== 3'b000) begin fails++; $display("FAIL kill_launch got %b want 000", ifc.Launch); end
        @(posedge clk); #1;
        tests++; if (ifc.FireCount !== 16'd0) begin fails++; $display("FAIL kill_count got %0d want 0", ifc.FireCount); end
        run_to_launch(20, n);
        tests++; if (n !== 2) begin fails++; $display("FAIL kill_rescan got %0d want 2", n); end
        tests++; if (ifc.LaunchX !== 10'd131) begin fails++; $display("FAIL kill_x got %0d want 131", ifc.LaunchX); end
    endtask

    task automatic test_enable_drop();
        int n;
        do_reset();
        ifc.Enable = 1'b1;
        repeat (6) @(posedge clk);
        #1 ifc.Enable = 1'b0;
        run_to_launch(2, n);
        tests++; if (n !== -1) begin fails++; $display("FAIL drop_no_launch got edge %0d want none", n); end
        ifc.Enable = 1'b1;
        run_to_launch(30, n);
        tests++; if (n !== 7) begin fails++; $display("FAIL drop_reload got %0d want 7", n); end
        tests++; if (ifc.LaunchX !== 10'd143) begin fails++; $display("FAIL drop_x got %0d want 143", ifc.LaunchX); end
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        ifc.Enable = 1'b1;
        run_to_launch(30, n);
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        tests++; if (ifc.LaunchX !== 10'd0) begin fails++; $display("FAIL arst_x got %0d want 0", ifc.LaunchX); end
        tests++; if (ifc.LaunchS !== 10'd0) begin fails++; $display("FAIL arst_s got %0d want 0", ifc.LaunchS); end
        tests++; if (ifc.FireCount !== 16'd0) begin fails++; $display("FAIL arst_count got %0d want 0", ifc.FireCount); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_to_launch(30, n);
        tests++; if (n !== 7) begin fails++; $display("FAIL arst_latency got %0d want 7", n); end
        tests++; if (ifc.LaunchX !== 10'd141) begin fails++; $display("FAIL arst_x_after got %0d want 141", ifc.LaunchX); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        ifc.Enable = 1'b0;
        ifc.SlotBusy = 3'b000;
        ifc.InvaderOn = '1;
        for (int i = 0; i < 50; i++) begin
            ifc.InvaderX[i] = 10'(100 + i);
            ifc.InvaderY[i] = 10'(200 + i);
        end
        test_reset();
        test_first_launch();
        test_empty_grid();
        test_all_busy();
        test_kill_in_fire();
        test_enable_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
